csr_unit: RTL and testbench

Control-and-status register file at the commit end of the LoongArch pipeline. It consumes the writeback-stage CSR/exception bus and performs masked CSR writes, exception entry and ERTN return state updates. It also runs the stable timer and raises the pipeline flush (`ex_en`) with its redirect target. It gives decode a combinational CSR read port and an interrupt-pending flag.

---
 rtl/csr_unit.sv | 209 ++++++++++++++++++++
 tb/tb_csr_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// LA32 control/status register file at the commit end of the pipeline: masked CSR writes,
// exception entry and ERTN return, stable timer, combinational read port and interrupt flag.
module csr_unit #(
  parameter int TIMER_W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [152:0] Wcsr_BUS,
  input  logic         ertn_W,
  input  logic [7:0]   hw_int,
  input  logic [13:0]  csr_raddr,
  output logic [31:0]  csr_rdata,
  output logic         ex_en,
  output logic [31:0]  ex_entry,
  output logic         has_int,
  output logic [1:0]   crmd_plv
);

  localparam logic [13:0] A_CRMD   = 14'h00;
  localparam logic [13:0] A_PRMD   = 14'h01;
  localparam logic [13:0] A_ECFG   = 14'h04;
  localparam logic [13:0] A_ESTAT  = 14'h05;
  localparam logic [13:0] A_ERA    = 14'h06;
  localparam logic [13:0] A_BADV   = 14'h07;
  localparam logic [13:0] A_EENTRY = 14'h0C;
  localparam logic [13:0] A_SAVE0  = 14'h30;
  localparam logic [13:0] A_SAVE1  = 14'h31;
  localparam logic [13:0] A_SAVE2  = 14'h32;
  localparam logic [13:0] A_SAVE3  = 14'h33;
  localparam logic [13:0] A_TID    = 14'h40;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  localparam logic [13:0] A_TICLR  = 14'h44;

  localparam logic [7:0]  ECODE_ADE = 8'h08;
  localparam logic [7:0]  ECODE_ALE = 8'h09;
  localparam logic [12:0] LIE_MASK  = 13'h1BFF;

  typedef struct packed {
    logic        ex;
    logic [7:0]  ecode;
    logic        esubcode;
    logic        csr_we;
    logic [13:0] csr_addr;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [31:0] pc;
    logic [31:0] vaddr;
  } wcsr_bus_t;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] m,
                                        input logic [31:0] d);
    return (old_v & ~m) | (d & m);
  endfunction

  wcsr_bus_t w_bus;
  assign w_bus = Wcsr_BUS;

  logic [1:0]         r_plv;
  logic               r_ie;
  logic               r_da;
  logic [1:0]         r_pplv;
  logic               r_pie;
  logic [12:0]        r_lie;
  logic [1:0]         r_is_sw;
  logic [7:0]         r_is_hw;
  logic               r_is_ti;
  logic [5:0]         r_ecode;
  logic [8:0]         r_esub;
  logic [31:0]        r_era;
  logic [31:0]        r_badv;
  logic [25:0]        r_eentry;
  logic [31:0]        r_save [4];
  logic [31:0]        r_tid;
  logic [TIMER_W-1:0] r_tcfg;
  logic [TIMER_W-1:0] r_tval;

  logic [31:0] w_wm, w_wd;
  logic        w_we;
  logic [12:0] w_is;
  logic [31:0] w_crmd, w_prmd, w_ecfg, w_estat, w_eentry, w_tcfg;
  logic [31:0] w_nv_crmd, w_nv_prmd, w_nv_ecfg, w_nv_estat, w_nv_eentry, w_nv_tcfg;
  logic        w_tcfg_wr, w_ticlr, w_tick, w_ti_set, w_badv_pc, w_badv_va;
  logic [TIMER_W-1:0] w_tcfg_load, w_tval_reload;

  // Writes are dropped when the same W-stage instruction is taking an exception.
  assign w_we = w_bus.csr_we & ~w_bus.ex;
  assign w_wm = w_bus.csr_wmask;
  assign w_wd = w_bus.csr_wdata;

  assign w_is     = {1'b0, r_is_ti, 1'b0, r_is_hw, r_is_sw};
  assign w_crmd   = {28'b0, r_da, r_ie, r_plv};
  assign w_prmd   = {29'b0, r_pie, r_pplv};
  assign w_ecfg   = {19'b0, r_lie};
  assign w_estat  = {1'b0, r_esub, r_ecode, 3'b0, w_is};
  assign w_eentry = {r_eentry, 6'b0};
  assign w_tcfg   = 32'(r_tcfg);

  assign w_nv_crmd   = merge(w_crmd, w_wm, w_wd);
  assign w_nv_prmd   = merge(w_prmd, w_wm, w_wd);
  assign w_nv_ecfg   = merge(w_ecfg, w_wm, w_wd);
  assign w_nv_estat  = merge(w_estat, w_wm, w_wd);
  assign w_nv_eentry = merge(w_eentry, w_wm, w_wd);
  assign w_nv_tcfg   = merge(w_tcfg, w_wm, w_wd);

  assign w_tcfg_wr     = w_we && (w_bus.csr_addr == A_TCFG);
  assign w_ticlr       = w_we && (w_bus.csr_addr == A_TICLR) && w_wd[0] && w_wm[0];
  assign w_tcfg_load   = {w_nv_tcfg[TIMER_W-1:2], 2'b00};
  assign w_tval_reload = {r_tcfg[TIMER_W-1:2], 2'b00};
  assign w_tick        = r_tcfg[0] && (r_tval != '0);
  // A TCFG write suppresses the decrement, so it also suppresses the 1->0 event.
  assign w_ti_set      = ~w_tcfg_wr && w_tick && (r_tval == TIMER_W'(1));

  assign w_badv_pc = (w_bus.ecode == ECODE_ADE) && ~w_bus.esubcode;
  assign w_badv_va = ((w_bus.ecode == ECODE_ADE) && w_bus.esubcode) || (w_bus.ecode == ECODE_ALE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_plv    <= '0;
      r_ie     <= 1'b0;
      r_da     <= 1'b1;
      r_pplv   <= '0;
      r_pie    <= 1'b0;
      r_lie    <= '0;
      r_is_sw  <= '0;
      r_is_hw  <= '0;
      r_is_ti  <= 1'b0;
      r_ecode  <= '0;
      r_esub   <= '0;
      r_era    <= '0;
      r_badv   <= '0;
      r_eentry <= '0;
      for (int i = 0; i < 4; i++) r_save[i] <= '0;
      r_tid    <= '0;
      r_tcfg   <= '0;
      r_tval   <= '0;
    end else begin
      r_is_hw <= hw_int;

      if (w_we) begin
        case (w_bus.csr_addr)
          A_CRMD:   {r_da, r_ie, r_plv} <= w_nv_crmd[3:0];
          A_PRMD:   {r_pie, r_pplv}     <= w_nv_prmd[2:0];
          A_ECFG:   r_lie     <= w_nv_ecfg[12:0] & LIE_MASK;
          A_ESTAT:  r_is_sw   <= w_nv_estat[1:0];
          A_ERA:    r_era     <= merge(r_era, w_wm, w_wd);
          A_BADV:   r_badv    <= merge(r_badv, w_wm, w_wd);
          A_EENTRY: r_eentry  <= w_nv_eentry[31:6];
          A_SAVE0:  r_save[0] <= merge(r_save[0], w_wm, w_wd);
          A_SAVE1:  r_save[1] <= merge(r_save[1], w_wm, w_wd);
          A_SAVE2:  r_save[2] <= merge(r_save[2], w_wm, w_wd);
          A_SAVE3:  r_save[3] <= merge(r_save[3], w_wm, w_wd);
          A_TID:    r_tid     <= merge(r_tid, w_wm, w_wd);
          A_TCFG:   r_tcfg    <= w_nv_tcfg[TIMER_W-1:0];
          default: ;
        endcase
      end

      if (w_bus.ex) begin
        r_pplv  <= r_plv;
        r_pie   <= r_ie;
        r_plv   <= '0;
        r_ie    <= 1'b0;
        r_era   <= w_bus.pc;
        r_ecode <= w_bus.ecode[5:0];
        r_esub  <= {8'b0, w_bus.esubcode};
        if (w_badv_pc)      r_badv <= w_bus.pc;
        else if (w_badv_va) r_badv <= w_bus.vaddr;
      end else if (ertn_W) begin
        r_plv <= r_pplv;
        r_ie  <= r_pie;
      end

      if (w_tcfg_wr)                         r_tval <= w_tcfg_load;
      else if (w_tick)                       r_tval <= r_tval - TIMER_W'(1);
      else if (r_tcfg[0] && r_tcfg[1])       r_tval <= w_tval_reload;

      if (w_ti_set)     r_is_ti <= 1'b1;
      else if (w_ticlr) r_is_ti <= 1'b0;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      A_CRMD:   csr_rdata = w_crmd;
      A_PRMD:   csr_rdata = w_prmd;
      A_ECFG:   csr_rdata = w_ecfg;
      A_ESTAT:  csr_rdata = w_estat;
      A_ERA:    csr_rdata = r_era;
      A_BADV:   csr_rdata = r_badv;
      A_EENTRY: csr_rdata = w_eentry;
      A_SAVE0:  csr_rdata = r_save[0];
      A_SAVE1:  csr_rdata = r_save[1];
      A_SAVE2:  csr_rdata = r_save[2];
      A_SAVE3:  csr_rdata = r_save[3];
      A_TID:    csr_rdata = r_tid;
      A_TCFG:   csr_rdata = w_tcfg;
      A_TVAL:   csr_rdata = 32'(r_tval);
      default: ;
    endcase
  end

  assign ex_en    = w_bus.ex | ertn_W;
  assign ex_entry = w_bus.ex ? w_eentry : r_era;
  assign has_int  = r_ie & |(w_is & r_lie);
  assign crmd_plv = r_plv;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: vector table for single-cycle behaviour, hand sequences
// for the timer, ex/ertn priority and mid-countdown reset.
module tb_csr_unit;
  localparam logic [13:0] A_CRMD = 14'h00, A_PRMD = 14'h01, A_ECFG = 14'h04, A_ESTAT = 14'h05;
  localparam logic [13:0] A_ERA = 14'h06, A_BADV = 14'h07, A_EENTRY = 14'h0C, A_SAVE0 = 14'h30;
  localparam logic [13:0] A_SAVE1 = 14'h31, A_TCFG = 14'h41, A_TVAL = 14'h42, A_TICLR = 14'h44;
  localparam logic [13:0] A_NONE = 14'h02;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic b_ex, b_esub, b_we;
  logic [7:0] b_ecode;
  logic [13:0] b_addr;
  logic [31:0] b_wm, b_wd, b_pc, b_va;
  logic [152:0] bus;
  logic ertn;
  logic [7:0] hw;
  logic [13:0] raddr;
  logic [31:0] rdata, ex_entry;
  logic ex_en, has_int;
  logic [1:0] crmd_plv;

  int checks = 0;
  int errors = 0;

  assign bus = {b_ex, b_ecode, b_esub, b_we, b_addr, b_wm, b_wd, b_pc, b_va};

  always #5 clk = ~clk;

  csr_unit #(.TIMER_W(32)) dut (
    .clk(clk), .rstn(rstn), .Wcsr_BUS(bus), .ertn_W(ertn), .hw_int(hw),
    .csr_raddr(raddr), .csr_rdata(rdata), .ex_en(ex_en), .ex_entry(ex_entry),
    .has_int(has_int), .crmd_plv(crmd_plv)
  );

  typedef struct {
    logic ex; logic [7:0] ecode; logic esub; logic we; logic [13:0] addr;
    logic [31:0] wm, wd, pc, va; logic ertn; logic [7:0] hw; logic [13:0] raddr;
    logic [31:0] erd; logic exen; logic ce; logic [31:0] eent; logic hint;
  } vec_t;
  vec_t vq[$];

  task automatic v(input logic ex, input logic [7:0] ecode, input logic esub, input logic we,
                   input logic [13:0] addr, input logic [31:0] wm, input logic [31:0] wd,
                   input logic [31:0] pc, input logic [31:0] va, input logic er,
                   input logic [7:0] h, input logic [13:0] ra, input logic [31:0] erd,
                   input logic exen, input logic ce, input logic [31:0] eent, input logic hint);
    vec_t t;
    t.ex = ex; t.ecode = ecode; t.esub = esub; t.we = we; t.addr = addr; t.wm = wm; t.wd = wd;
    t.pc = pc; t.va = va; t.ertn = er; t.hw = h; t.raddr = ra; t.erd = erd; t.exen = exen;
    t.ce = ce; t.eent = eent; t.hint = hint;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    b_ex = 0; b_ecode = 0; b_esub = 0; b_we = 0; b_addr = 0; b_wm = 0; b_wd = 0;
    b_pc = 0; b_va = 0; ertn = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] d);
    b_we = 1; b_addr = a; b_wm = m; b_wd = d;
    step();
    idle();
  endtask

  task automatic rd(input string nm, input logic [13:0] a, input logic [31:0] exp);
    raddr = a; #1;
    chk(nm, rdata, exp);
  endtask

  task automatic rd_ti(input string nm, input logic exp);
    raddr = A_ESTAT; #1;
    chk(nm, {31'b0, rdata[11]}, {31'b0, exp});
  endtask

  task automatic wait_tval1(input string nm);
    logic found;
    found = 0;
    for (int k = 0; k < 24 && !found; k++) begin
      raddr = A_TVAL; #1;
      if (rdata == 32'd1) found = 1;
      else step();
    end
    chk(nm, {31'b0, found}, 32'd1);
  endtask

  initial begin
    idle(); hw = 0; raddr = 0;
    //  ex ec  es we addr      wmask         wdata         pc            vaddr     ertn hw     raddr     rdata         exen ce entry         hint
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_CRMD,   32'h8,        0, 1, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_ESTAT,  0,            0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_TVAL,   0,            0, 0, 0,             0);
    v(0, 0,    0, 1, A_SAVE0,  32'hFFFFFFFF, 32'h12345678, 0,            0,         0, 0,     A_SAVE0,  0,            0, 0, 0,             0);
    v(0, 0,    0, 1, A_SAVE0,  32'h0000FFFF, 32'hDEADBEEF, 0,            0,         0, 0,     A_SAVE0,  32'h12345678, 0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_SAVE0,  32'h1234BEEF, 0, 0, 0,             0);
    v(0, 0,    0, 1, A_CRMD,   32'hFFFFFFFF, 32'h7,        0,            0,         0, 0,     A_CRMD,   32'h8,        0, 0, 0,             0);
    v(0, 0,    0, 1, A_EENTRY, 32'hFFFFFFFF, 32'h1C00803F, 0,            0,         0, 0,     A_CRMD,   32'h7,        0, 0, 0,             0);
    v(0, 0,    0, 1, A_ECFG,   32'h0000FFFF, 32'hFFFFFFFF, 0,            0,         0, 0,     A_EENTRY, 32'h1C008000, 0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_ECFG,   32'h1BFF,     0, 0, 0,             0);
    v(1, 8'h09,0, 1, A_SAVE1,  32'hFFFFFFFF, 32'hAAAA5555, 32'h1C000010, 32'h1003,  0, 0,     A_CRMD,   32'h7,        1, 1, 32'h1C008000,  0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_ERA,    32'h1C000010, 0, 1, 32'h1C000010,  0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_BADV,   32'h1003,     0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_PRMD,   32'h7,        0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_CRMD,   32'h0,        0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_ESTAT,  32'h00090000, 0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_SAVE1,  0,            0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         1, 0,     A_CRMD,   32'h0,        1, 1, 32'h1C000010,  0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_CRMD,   32'h7,        0, 0, 0,             0);
    v(1, 8'h08,0, 0, 0,        0,            0,            32'h1C000020, 32'h55,    0, 0,     A_ESTAT,  32'h00090000, 1, 1, 32'h1C008000,  0);
    v(1, 8'h08,1, 0, 0,        0,            0,            32'h1C000030, 32'h77,    0, 0,     A_BADV,   32'h1C000020, 1, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_BADV,   32'h77,       0, 0, 0,             0);
    v(1, 8'h0A,0, 0, 0,        0,            0,            32'h1C000040, 32'h99,    0, 0,     A_ESTAT,  32'h00480000, 1, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_BADV,   32'h77,       0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_ERA,    32'h1C000040, 0, 1, 32'h1C000040,  0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 8'hA5, A_ESTAT,  32'h000A0000, 0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 8'hA5, A_ESTAT,  32'h000A0294, 0, 0, 0,             0);
    v(0, 0,    0, 1, A_CRMD,   32'h4,        32'h4,        0,            0,         0, 8'hA5, A_ESTAT,  32'h000A0294, 0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 8'hA5, A_CRMD,   32'h4,        0, 0, 0,             1);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_ESTAT,  32'h000A0294, 0, 0, 0,             1);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_ESTAT,  32'h000A0000, 0, 0, 0,             0);
    v(0, 0,    0, 1, A_ESTAT,  32'hFFFFFFFF, 32'hFFFFFFFF, 0,            0,         0, 0,     A_TICLR,  0,            0, 0, 0,             0);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_ESTAT,  32'h000A0003, 0, 0, 0,             1);
    v(0, 0,    0, 1, A_ESTAT,  32'h3,        32'h0,        0,            0,         0, 0,     A_NONE,   0,            0, 0, 0,             1);
    v(0, 0,    0, 0, 0,        0,            0,            0,            0,         0, 0,     A_ESTAT,  32'h000A0000, 0, 0, 0,             0);

    // Reset held: no redirect.
    step();
    chk("reset_ex_en", {31'b0, ex_en}, 0);
    step();
    rstn = 1;

    for (int i = 0; i < vq.size(); i++) begin
      b_ex = vq[i].ex; b_ecode = vq[i].ecode; b_esub = vq[i].esub; b_we = vq[i].we;
      b_addr = vq[i].addr; b_wm = vq[i].wm; b_wd = vq[i].wd; b_pc = vq[i].pc; b_va = vq[i].va;
      ertn = vq[i].ertn; hw = vq[i].hw; raddr = vq[i].raddr;
      @(negedge clk);
      chk($sformatf("row%0d rdata", i), rdata, vq[i].erd);
      chk($sformatf("row%0d ex_en", i), {31'b0, ex_en}, {31'b0, vq[i].exen});
      chk($sformatf("row%0d has_int", i), {31'b0, has_int}, {31'b0, vq[i].hint});
      if (vq[i].ce) chk($sformatf("row%0d ex_entry", i), ex_entry, vq[i].eent);
      if (vq[i].raddr == A_CRMD) chk($sformatf("row%0d plv", i), {30'b0, crmd_plv}, {30'b0, vq[i].erd[1:0]});
      @(posedge clk); #1;
    end
    idle(); hw = 0;

    // Periodic timer: InitVal 2 -> TVAL 8, expires after 8 decrements, then reloads.
    wr(A_TCFG, 32'hFFFFFFFF, 32'h0000000B);
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("tval_cnt%0d", i), A_TVAL, 32'(8 - i));
      step();
    end
    rd("tval_zero", A_TVAL, 0);
    rd_ti("ti_set", 1);
    chk("has_int_timer", {31'b0, has_int}, 1);
    step();
    rd("tval_reload", A_TVAL, 8);
    wr(A_TICLR, 32'h1, 32'h1);
    rd_ti("ticlr_clear", 0);
    chk("has_int_cleared", {31'b0, has_int}, 0);

    // Timer set and TICLR in the same cycle: set wins.
    wait_tval1("wait_tval1_a");
    wr(A_TICLR, 32'h1, 32'h1);
    rd_ti("set_beats_clear", 1);
    wr(A_TICLR, 32'h1, 32'h1);
    rd_ti("ticlr_clear2", 0);

    // TCFG write on the expiring cycle: reload from the new value, no expiry event.
    wait_tval1("wait_tval1_b");
    wr(A_TCFG, 32'hFFFFFFFF, 32'h00000011);
    rd("tcfg_override", A_TVAL, 16);
    rd_ti("tcfg_no_set", 0);
    for (int i = 0; i < 20; i++) step();
    rd("oneshot_hold", A_TVAL, 0);
    rd_ti("oneshot_set", 1);

    // ex and ertn together: ex wins.
    wr(A_CRMD, 32'hFFFFFFFF, 32'h7);
    b_ex = 1; b_ecode = 8'h0A; b_pc = 32'h1C000050; ertn = 1; #1;
    chk("both_ex_en", {31'b0, ex_en}, 1);
    chk("both_entry", ex_entry, 32'h1C008000);
    step();
    idle();
    rd("both_crmd", A_CRMD, 32'h0);
    rd("both_era", A_ERA, 32'h1C000050);
    rd("both_prmd", A_PRMD, 32'h7);

    // Reset in mid-countdown.
    wr(A_TCFG, 32'hFFFFFFFF, 32'h0000000B);
    step(); step();
    hw = 8'h03;
    rstn = 0; #1;
    chk("rst_ex_en", {31'b0, ex_en}, 0);
    step();
    rd("rst_crmd", A_CRMD, 32'h8);
    rd("rst_tval", A_TVAL, 0);
    rd("rst_estat", A_ESTAT, 0);
    rd("rst_ecfg", A_ECFG, 0);
    chk("rst_has_int", {31'b0, has_int}, 0);
    step();
    rstn = 1;
    step(); step();
    rd("post_rst_tval", A_TVAL, 0);
    rd("post_rst_hw", A_ESTAT, 32'h0000000C);
    chk("post_rst_has_int", {31'b0, has_int}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
